// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and 50 MHz refclk timing defaults for the PLL reset sequencer.
package pll_reset_sequencer_pkg;

   typedef enum logic [2:0] {
      PLL_RESET,
      WAIT_LOCK,
      STABLE,
      RELEASE,
      RUN
   } seq_state_e;

   localparam int DEF_PLL_RST_CYCLES      = 16;
   localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
   localparam int DEF_LOCK_TIMEOUT_CYCLES = 1000000;
   localparam int DEF_STAGE_GAP_CYCLES    = 64;
   localparam int DEF_NUM_STAGES          = 3;
   localparam int DEF_SYNC_STAGES         = 2;

   localparam int STAGE_PIXEL = 0;
   localparam int STAGE_MEM   = 1;
   localparam int STAGE_GAME  = 2;

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous level into the local clock domain.
module bit_synchronizer #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk) begin
      if (rst) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock qualification and ordered release of downstream reset domains.
//
// state     | meaning
// PLL_RESET | pll_rst held high for PLL_RST_CYCLES, all domains in reset
// WAIT_LOCK | pll_rst low, waiting for synchronized lock; retry on timeout
// STABLE    | lock must stay high LOCK_STABLE_CYCLES in a row
// RELEASE   | domains leave reset in ascending index, STAGE_GAP_CYCLES apart
// RUN       | all domains out of reset, ready high
module pll_reset_sequencer
   import pll_reset_sequencer_pkg::*;
#(
   parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
   parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
   parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
   parameter int STAGE_GAP_CYCLES    = DEF_STAGE_GAP_CYCLES,
   parameter int NUM_STAGES          = DEF_NUM_STAGES,
   parameter int SYNC_STAGES         = DEF_SYNC_STAGES
) (
   input  logic                  refclk,
   input  logic                  rst,
   input  logic                  locked,
   output logic                  pll_rst,
   output logic [NUM_STAGES-1:0] rst_out,
   output logic                  ready,
   output logic [7:0]            relock_count
);

   localparam int CNT_MAX = max_of(max_of(PLL_RST_CYCLES, LOCK_STABLE_CYCLES),
                                   max_of(LOCK_TIMEOUT_CYCLES, STAGE_GAP_CYCLES));
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;

   localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
   localparam logic [CNT_W-1:0] LD_PLL_RST    = CNT_W'(PLL_RST_CYCLES);
   localparam logic [CNT_W-1:0] LD_PLL_RST_M1 = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] LD_STABLE     = CNT_W'(LOCK_STABLE_CYCLES);
   localparam logic [CNT_W-1:0] LD_TIMEOUT    = CNT_W'(LOCK_TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] LD_GAP        = CNT_W'(STAGE_GAP_CYCLES);

   seq_state_e            state, state_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic [NUM_STAGES-1:0] rst_out_nxt;
   logic [7:0]            relock_nxt;
   logic                  locked_s;
   logic                  cnt_tc;

   bit_synchronizer #(
      .STAGES (SYNC_STAGES)
   ) u_lock_sync (
      .clk (refclk),
      .rst (rst),
      .d   (locked),
      .q   (locked_s)
   );

   assign cnt_tc  = (cnt == CNT_ONE);
   assign pll_rst = (state == PLL_RESET);
   assign ready   = (state == RUN);

   always_ff @(posedge refclk) begin
      if (rst) begin
         state        <= PLL_RESET;
         cnt          <= '0;
         rst_out      <= '1;
         relock_count <= '0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         rst_out      <= rst_out_nxt;
         relock_count <= relock_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt - CNT_ONE;
      rst_out_nxt = rst_out;
      relock_nxt  = relock_count;

      case (state)
         PLL_RESET: begin
            rst_out_nxt = '1;
            // A zero count only occurs straight out of rst; it stands in for the first pulse cycle.
            if (cnt_tc || (cnt == '0 && PLL_RST_CYCLES == 1)) begin
               state_nxt = WAIT_LOCK;
               cnt_nxt   = LD_TIMEOUT;
            end else if (cnt == '0) begin
               cnt_nxt = LD_PLL_RST_M1;
            end
         end
         WAIT_LOCK: begin
            if (locked_s) begin
               state_nxt = STABLE;
               cnt_nxt   = LD_STABLE;
            end else if (cnt_tc) begin
               state_nxt = PLL_RESET;
               cnt_nxt   = LD_PLL_RST;
            end
         end
         STABLE: begin
            if (!locked_s) begin
               state_nxt = WAIT_LOCK;
               cnt_nxt   = LD_TIMEOUT;
            end else if (cnt_tc) begin
               state_nxt   = RELEASE;
               cnt_nxt     = LD_GAP;
               rst_out_nxt = rst_out << 1;
            end
         end
         RELEASE: begin
            if (!locked_s) begin
               state_nxt   = PLL_RESET;
               cnt_nxt     = LD_PLL_RST;
               rst_out_nxt = '1;
               if (relock_count != 8'hFF) relock_nxt = relock_count + 8'd1;
            end else if (rst_out == '0) begin
               state_nxt = RUN;
               cnt_nxt   = cnt;
            end else if (cnt_tc) begin
               cnt_nxt     = LD_GAP;
               rst_out_nxt = rst_out << 1;
            end
         end
         RUN: begin
            cnt_nxt = cnt;
            if (!locked_s) begin
               state_nxt   = PLL_RESET;
               cnt_nxt     = LD_PLL_RST;
               rst_out_nxt = '1;
               if (relock_count != 8'hFF) relock_nxt = relock_count + 8'd1;
            end
         end
         default: begin
            state_nxt   = PLL_RESET;
            cnt_nxt     = LD_PLL_RST;
            rst_out_nxt = '1;
         end
      endcase
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench: vector table, corner-case sequences and random lock traffic vs a phase model.
module tb_pll_reset_sequencer;

   localparam int P_RST    = 4;
   localparam int P_STABLE = 8;
   localparam int P_GAP    = 3;
   localparam int P_TO     = 50;
   localparam int P_NS     = 3;
   localparam int P_SYNC   = 2;

   logic            refclk = 1'b0;
   logic            rst;
   logic            locked;
   logic            pll_rst;
   logic [P_NS-1:0] rst_out;
   logic            ready;
   logic [7:0]      relock_count;

   int checks = 0;
   int errors = 0;

   always #5 refclk = ~refclk;

   pll_reset_sequencer #(
      .PLL_RST_CYCLES      (P_RST),
      .LOCK_STABLE_CYCLES  (P_STABLE),
      .LOCK_TIMEOUT_CYCLES (P_TO),
      .STAGE_GAP_CYCLES    (P_GAP),
      .NUM_STAGES          (P_NS),
      .SYNC_STAGES         (P_SYNC)
   ) dut (
      .refclk       (refclk),
      .rst          (rst),
      .locked       (locked),
      .pll_rst      (pll_rst),
      .rst_out      (rst_out),
      .ready        (ready),
      .relock_count (relock_count)
   );

   // Reference model: phase name plus elapsed cycles and number of released domains.
   typedef enum int {M_PULSE, M_WAIT, M_QUAL, M_REL, M_RUN} mphase_t;
   mphase_t m_phase = M_PULSE;
   int      m_elapsed = 0;
   int      m_released = 0;
   int      m_relock = 0;
   bit      m_sync[$] = '{0, 0};

   function automatic logic [P_NS-1:0] m_mask(input int released);
      logic [P_NS-1:0] v;
      for (int i = 0; i < P_NS; i++) v[i] = (i >= released);
      return v;
   endfunction

   task automatic m_loss();
      m_phase    = M_PULSE;
      m_elapsed  = 0;
      m_released = 0;
      if (m_relock < 255) m_relock++;
   endtask

   task automatic model_step(input logic r, input logic l);
      bit ls;
      if (r) begin
         m_phase    = M_PULSE;
         m_elapsed  = 0;
         m_released = 0;
         m_relock   = 0;
         m_sync     = {};
         for (int i = 0; i < P_SYNC; i++) m_sync.push_back(1'b0);
      end else begin
         ls = m_sync[$];
         m_sync.push_front(l);
         void'(m_sync.pop_back());
         case (m_phase)
            M_PULSE: begin
               m_elapsed++;
               if (m_elapsed == P_RST) begin m_phase = M_WAIT; m_elapsed = 0; end
            end
            M_WAIT: begin
               if (ls) begin
                  m_phase = M_QUAL; m_elapsed = 0;
               end else begin
                  m_elapsed++;
                  if (m_elapsed == P_TO) begin m_phase = M_PULSE; m_elapsed = 0; end
               end
            end
            M_QUAL: begin
               if (!ls) begin
                  m_phase = M_WAIT; m_elapsed = 0;
               end else begin
                  m_elapsed++;
                  if (m_elapsed == P_STABLE) begin
                     m_phase = M_REL; m_elapsed = 0; m_released = 1;
                  end
               end
            end
            M_REL: begin
               if (!ls) m_loss();
               else if (m_released == P_NS) m_phase = M_RUN;
               else begin
                  m_elapsed++;
                  if (m_elapsed == P_GAP) begin m_released++; m_elapsed = 0; end
               end
            end
            default: if (!ls) m_loss();
         endcase
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
      end
   endtask

   // One refclk edge: predict, let the DUT clock, then compare on the falling edge.
   task automatic cycle();
      model_step(rst, locked);
      @(negedge refclk);
      chk("model_pll_rst", 32'(pll_rst), 32'(m_phase == M_PULSE));
      chk("model_rst_out", 32'(rst_out), 32'(m_mask(m_released)));
      chk("model_ready", 32'(ready), 32'(m_phase == M_RUN));
      chk("model_relock", 32'(relock_count), 32'(m_relock));
      if (ready) chk("inv_ready_rst_out", 32'(rst_out), 32'd0);
      if (pll_rst) chk("inv_pll_rst_rst_out", 32'(rst_out), 32'(3'b111));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      locked = 1'b0;
      cycle();
      cycle();
      rst = 1'b0;
   endtask

   typedef struct {
      logic       r;
      logic       l;
      int         n;
      logic       e_pll;
      logic [2:0] e_rst;
      logic       e_rdy;
      logic [7:0] e_cnt;
   } vec_t;

   vec_t tbl[15];

   initial begin
      int lat;
      int k;
      int seg;
      bit hit;

      tbl[0]  = '{1'b1, 1'b0, 2,  1'b1, 3'b111, 1'b0, 8'd0};
      tbl[1]  = '{1'b0, 1'b0, 3,  1'b1, 3'b111, 1'b0, 8'd0};
      tbl[2]  = '{1'b0, 1'b0, 1,  1'b0, 3'b111, 1'b0, 8'd0};
      tbl[3]  = '{1'b0, 1'b0, 6,  1'b0, 3'b111, 1'b0, 8'd0};
      tbl[4]  = '{1'b0, 1'b1, 10, 1'b0, 3'b111, 1'b0, 8'd0};
      tbl[5]  = '{1'b0, 1'b1, 1,  1'b0, 3'b110, 1'b0, 8'd0};
      tbl[6]  = '{1'b0, 1'b1, 2,  1'b0, 3'b110, 1'b0, 8'd0};
      tbl[7]  = '{1'b0, 1'b1, 1,  1'b0, 3'b100, 1'b0, 8'd0};
      tbl[8]  = '{1'b0, 1'b1, 3,  1'b0, 3'b000, 1'b0, 8'd0};
      tbl[9]  = '{1'b0, 1'b1, 1,  1'b0, 3'b000, 1'b1, 8'd0};
      tbl[10] = '{1'b0, 1'b1, 5,  1'b0, 3'b000, 1'b1, 8'd0};
      tbl[11] = '{1'b0, 1'b0, 2,  1'b0, 3'b000, 1'b1, 8'd0};
      tbl[12] = '{1'b0, 1'b0, 1,  1'b1, 3'b111, 1'b0, 8'd1};
      tbl[13] = '{1'b0, 1'b0, 3,  1'b1, 3'b111, 1'b0, 8'd1};
      tbl[14] = '{1'b0, 1'b0, 1,  1'b0, 3'b111, 1'b0, 8'd1};

      rst = 1'b1;
      locked = 1'b0;

      // Nominal bring-up followed by lock loss in RUN.
      for (int i = 0; i < 15; i++) begin
         rst = tbl[i].r;
         locked = tbl[i].l;
         repeat (tbl[i].n) cycle();
         chk($sformatf("vec%0d_pll_rst", i), 32'(pll_rst), 32'(tbl[i].e_pll));
         chk($sformatf("vec%0d_rst_out", i), 32'(rst_out), 32'(tbl[i].e_rst));
         chk($sformatf("vec%0d_ready", i), 32'(ready), 32'(tbl[i].e_rdy));
         chk($sformatf("vec%0d_relock", i), 32'(relock_count), 32'(tbl[i].e_cnt));
      end

      // Latency from rst release with locked held high.
      do_reset();
      locked = 1'b1;
      lat = 0;
      hit = 1'b0;
      while (!hit && lat < 200) begin
         cycle();
         lat++;
         hit = ready;
      end
      checks++;
      if (!hit || lat < (P_RST + P_SYNC + P_STABLE + (P_NS-1)*P_GAP) - 2 ||
          lat > (P_RST + P_SYNC + P_STABLE + (P_NS-1)*P_GAP) + 2) begin
         errors++;
         $display("FAIL latency: actual=%0d expected=%0d+-2", lat,
                  P_RST + P_SYNC + P_STABLE + (P_NS-1)*P_GAP);
      end

      // One-cycle lock glitch during qualification restarts the stable window.
      do_reset();
      locked = 1'b1;
      repeat (10) cycle();
      locked = 1'b0;
      cycle();
      locked = 1'b1;
      repeat (10) cycle();
      chk("glitch_no_early_release", 32'(rst_out), 32'(3'b111));
      cycle();
      chk("glitch_release_after_window", 32'(rst_out), 32'(3'b110));

      // Timeout retries every P_TO + P_RST cycles with locked low.
      do_reset();
      for (k = 1; k <= 120; k++) begin
         cycle();
         if (k == 53) chk("timeout_pll_rst_low_53", 32'(pll_rst), 32'd0);
         if (k == 54) chk("timeout_pll_rst_high_54", 32'(pll_rst), 32'd1);
         if (k == 57) chk("timeout_pll_rst_high_57", 32'(pll_rst), 32'd1);
         if (k == 58) chk("timeout_pll_rst_low_58", 32'(pll_rst), 32'd0);
         if (k == 108) chk("timeout_pll_rst_high_108", 32'(pll_rst), 32'd1);
         if (ready) chk("timeout_ready_never", 32'(ready), 32'd0);
      end

      // Lock arriving on the timeout cycle wins; one cycle later it does not.
      do_reset();
      for (k = 1; k <= 54; k++) begin
         locked = (k >= 52);
         cycle();
      end
      chk("tie_lock_wins", 32'(pll_rst), 32'd0);
      do_reset();
      for (k = 1; k <= 54; k++) begin
         locked = (k >= 53);
         cycle();
      end
      chk("late_lock_timeout", 32'(pll_rst), 32'd1);

      // Lock loss mid-release.
      do_reset();
      locked = 1'b1;
      repeat (13) cycle();
      chk("midrel_first_stage", 32'(rst_out), 32'(3'b110));
      locked = 1'b0;
      cycle();
      cycle();
      chk("midrel_before_react", 32'(rst_out), 32'(3'b110));
      cycle();
      chk("midrel_rst_out", 32'(rst_out), 32'(3'b111));
      chk("midrel_pll_rst", 32'(pll_rst), 32'd1);
      chk("midrel_relock", 32'(relock_count), 32'd1);
      locked = 1'b1;
      k = 0;
      while (!ready && k < 200) begin cycle(); k++; end
      chk("midrel_rebringup_ready", 32'(ready), 32'd1);

      // Saturation of relock_count, then synchronous reset.
      do_reset();
      locked = 1'b1;
      for (int n = 0; n < 260; n++) begin
         k = 0;
         while (rst_out == 3'b111 && k < 100) begin cycle(); k++; end
         locked = 1'b0;
         k = 0;
         while (!pll_rst && k < 10) begin cycle(); k++; end
         locked = 1'b1;
      end
      chk("sat_relock_255", 32'(relock_count), 32'd255);
      k = 0;
      while (rst_out == 3'b111 && k < 100) begin cycle(); k++; end
      rst = 1'b1;
      cycle();
      chk("rst_pll_rst", 32'(pll_rst), 32'd1);
      chk("rst_rst_out", 32'(rst_out), 32'(3'b111));
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_relock", 32'(relock_count), 32'd0);
      rst = 1'b0;

      // Random lock traffic with occasional resets.
      k = 0;
      while (k < 3000) begin
         locked = 1'($urandom_range(0, 1));
         seg = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 70);
         rst = ($urandom_range(0, 199) == 0);
         for (int j = 0; j < seg; j++) begin
            cycle();
            rst = 1'b0;
            k++;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
